// File: rtl/huff_bit_feeder_if.sv
// Handshake bundle between the byte source, the bit feeder and the decoder.
// Latency: none (wires only).
// Backpressure: s_valid/s_ready on the byte side; sValid/aready on the chunk side.
//
// Signals:
//   s_data/s_valid/s_last/s_nbits : byte stream in (LSB-first), s_ready back
//   in_bits/in_len/sValid         : chunk out to decoder, aready back
//   stream_done                   : one-cycle end-of-stream pulse
//   bits_sent                     : running count of consumed bits (mod 2^16)
interface huff_bit_feeder_if #(
   parameter int BYTE_W = 8
);
   logic [BYTE_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic [3:0]        s_nbits;
   logic              s_ready;
   logic [3:0]        in_bits;
   logic [2:0]        in_len;
   logic              sValid;
   logic              aready;
   logic              stream_done;
   logic [15:0]       bits_sent;

   // master: drives the byte stream and the decoder's accept
   modport master (
      output s_data, s_valid, s_last, s_nbits, aready,
      input  s_ready, in_bits, in_len, sValid, stream_done, bits_sent
   );

   // slave: the bit feeder itself
   modport slave (
      input  s_data, s_valid, s_last, s_nbits, aready,
      output s_ready, in_bits, in_len, sValid, stream_done, bits_sent
   );
endinterface

// File: rtl/huff_bit_feeder.sv
// Splits an LSB-first byte stream into chunks of up to CHUNK_MAX bits for a decoder.
// Latency: first chunk valid the cycle after a byte is accepted; back-to-back bytes with no bubble.
// Backpressure: chunk holds while aready=0; s_ready only opens in IDLE or on the final chunk transfer.
//
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : huff_bit_feeder_if.slave (byte stream in, chunk stream out,
//                stream_done pulse, bits_sent counter)
module huff_bit_feeder #(
   parameter int CHUNK_MAX = 4,
   parameter int BYTE_W    = 8
) (
   input logic               clk,
   input logic               reset,
   huff_bit_feeder_if.slave  bus
);

   localparam int REM_W = $clog2(BYTE_W + 1);
   localparam logic [REM_W-1:0] CHUNK_REM = REM_W'(CHUNK_MAX);
   localparam logic [2:0]       CHUNK_LEN = 3'(CHUNK_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [BYTE_W-1:0] byte_reg_q, byte_reg_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic              last_reg_q, last_reg_d;
   logic [15:0]       bits_sent_q, bits_sent_d;

   logic [2:0]        chunk_len;
   logic [3:0]        chunk_bits;
   logic [REM_W-1:0]  load_rem;
   logic              xfer;
   logic              final_chunk;
   logic              s_ready;
   logic              accept;

   // Bit count for a freshly loaded byte: only a last byte may be short, and
   // an out-of-range count (0 or wider than the byte) means a full byte.
   always_comb begin
      load_rem = REM_W'(BYTE_W);
      if (bus.s_last && (bus.s_nbits != 4'd0) && (int'(bus.s_nbits) <= BYTE_W)) begin
         load_rem = REM_W'(bus.s_nbits);
      end
   end

   // Current chunk: min(rem, CHUNK_MAX) oldest bits, upper bits forced to zero.
   // Outside EMIT the length is zero, which also zeroes the data.
   always_comb begin
      chunk_len = 3'd0;
      if (state_q == EMIT) begin
         chunk_len = (rem_q < CHUNK_REM) ? 3'(rem_q) : CHUNK_LEN;
      end
      chunk_bits = byte_reg_q[3:0] & ~(4'hF << chunk_len);
   end

   assign xfer        = (state_q == EMIT) && bus.aready;
   assign final_chunk = (REM_W'(chunk_len) == rem_q);

   // s_ready never looks at s_valid. In EMIT it opens only when the last chunk
   // of a non-final byte is leaving, so the next byte loads with no bubble.
   always_comb begin
      s_ready = 1'b0;
      case (state_q)
         IDLE:    s_ready = 1'b1;
         EMIT:    s_ready = xfer && final_chunk && !last_reg_q;
         default: s_ready = 1'b0;
      endcase
      if (reset) begin
         s_ready = 1'b0;
      end
   end

   assign accept = s_ready && bus.s_valid;

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      byte_reg_d  = byte_reg_q;
      rem_d       = rem_q;
      last_reg_d  = last_reg_q;
      bits_sent_d = bits_sent_q;

      if (xfer) begin
         byte_reg_d  = byte_reg_q >> chunk_len;
         rem_d       = rem_q - REM_W'(chunk_len);
         bits_sent_d = bits_sent_q + 16'(chunk_len);
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               byte_reg_d = bus.s_data;
               last_reg_d = bus.s_last;
               rem_d      = load_rem;
               state_d    = EMIT;
            end
         end
         EMIT: begin
            if (xfer && final_chunk) begin
               if (last_reg_q) begin
                  state_d = DONE;
               end else if (accept) begin
                  // reload overrides the shift/decrement of the outgoing byte
                  byte_reg_d = bus.s_data;
                  last_reg_d = bus.s_last;
                  rem_d      = load_rem;
                  state_d    = EMIT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DONE: begin
            last_reg_d = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         byte_reg_q  <= '0;
         rem_q       <= '0;
         last_reg_q  <= 1'b0;
         bits_sent_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         byte_reg_q  <= byte_reg_d;
         rem_q       <= rem_d;
         last_reg_q  <= last_reg_d;
         bits_sent_q <= bits_sent_d;
      end
   end

   // Outputs decode straight from registered state, so reset clears them at once.
   assign bus.s_ready     = s_ready;
   assign bus.in_bits     = chunk_bits;
   assign bus.in_len      = chunk_len;
   assign bus.sValid      = (state_q == EMIT);
   assign bus.stream_done = (state_q == DONE);
   assign bus.bits_sent   = bits_sent_q;

endmodule

// File: doc/huff_bit_feeder.md
HUFF_BIT_FEEDER -- requirements
Module: huff_bit_feeder

Interface
REQ-001 Parameter CHUNK_MAX, default 4: maximum bits emitted per output beat; legal range 1..4.
REQ-002 Parameter BYTE_W, default 8: width of the input byte.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port s_data, input, BYTE_W: compressed stream byte, LSB-first bit order.
REQ-006 Port s_valid, input, 1: s_data, s_last and s_nbits are valid.
REQ-007 Port s_last, input, 1: marks the final byte of a stream.
REQ-008 Port s_nbits, input, 4: number of valid bits in the last byte; sampled only with s_last; 0 or >BYTE_W means BYTE_W.
REQ-009 Port s_ready, output, 1: the block accepts a byte this cycle.
REQ-010 Port in_bits, output, 4: chunk for the decoder's shift buffer; bit 0 is the oldest bit.
REQ-011 Port in_len, output, 3: number of valid bits in in_bits, 1..CHUNK_MAX.
REQ-012 Port sValid, output, 1: in_bits and in_len are valid.
REQ-013 Port aready, input, 1: the decoder consumes the current chunk.
REQ-014 Port stream_done, output, 1: one-cycle pulse after the final chunk of a stream is consumed.
REQ-015 Port bits_sent, output, 16: running count of bits consumed by the decoder.

Function
REQ-016 FSM states are IDLE, EMIT and DONE, held in a registered state variable.
REQ-017 An input byte is accepted when s_valid && s_ready; there is no combinational path from s_valid to s_ready.
REQ-018 IDLE behaviour:
- s_ready=1 and sValid=0.
- On accept, latch s_data into byte_reg and s_last into last_reg.
- Set rem = BYTE_W, or the effective s_nbits when s_last=1.
- Go to EMIT.
REQ-019 EMIT output:
- sValid=1.
- in_len = min(rem, CHUNK_MAX).
- in_bits = byte_reg[in_len-1:0], zero-extended; bits at and above in_len are 0.
REQ-020 A chunk transfers when sValid && aready. On transfer:
- byte_reg shifts right by in_len.
- rem decreases by in_len.
- bits_sent increases by in_len.
REQ-021 While sValid=1 and aready=0, in_bits, in_len and sValid hold unchanged.
REQ-022 EMIT, transfer with rem==in_len and last_reg=0:
- s_ready=1 in that cycle (zero-bubble).
- If a byte is accepted, reload per REQ-018 and stay in EMIT.
- Otherwise go to IDLE.
REQ-023 EMIT, transfer with rem==in_len and last_reg=1: s_ready=0 and go to DONE.
REQ-024 s_ready=0 in EMIT in every case not covered by REQ-022, and in DONE.
REQ-025 DONE: assert stream_done=1 for exactly one cycle, keep sValid=0, then go to IDLE.
REQ-026 bits_sent wraps modulo 2^16 and clears only on reset.
REQ-027 Chunk sizing: a full byte with CHUNK_MAX=4 produces exactly two chunks of 4 bits; a partial final byte produces ceil(n/CHUNK_MAX) chunks, with any short chunk last.
REQ-028 s_data, s_last and s_nbits are ignored when s_ready=0.

Reset
REQ-029 Asserting reset forces the following immediately, regardless of clk:
- state=IDLE, byte_reg=0, rem=0, last_reg=0.
- in_bits=0, in_len=0, sValid=0, stream_done=0, bits_sent=0.
- s_ready=0 while reset is high.
REQ-030 Reset mid-stream discards all partial byte state. After release, the first accepted byte starts a new stream and no residual chunk is emitted.
REQ-031 s_ready is 1 on the first clk edge after reset deasserts.

Verification
REQ-032 Basic split: s_data=0xA5, s_last=0, aready=1 -> chunks (in_bits=0x5, in_len=4) then (0xA, 4); bits_sent=8; no idle cycle if a next byte is offered.
REQ-033 Back-pressure: hold aready=0 for 5 cycles during chunk 1 of 0x3C -> in_bits=0xC and in_len=4 stable for all 5 cycles; then 0x3 follows after aready rises.
REQ-034 Partial last byte: s_data=0x7F, s_last=1, s_nbits=6 -> chunks (0xF, 4) then (0x3, 2); stream_done pulses exactly one cycle after the second transfer.
REQ-035 Back-to-back streaming: 4 bytes with s_valid held high and aready=1 -> 8 consecutive sValid cycles, no gaps, bits_sent=32.
REQ-036 Reset mid-operation: assert reset after the first chunk of 0xA5 -> sValid=0 and bits_sent=0 immediately; next byte 0x12 yields (0x2, 4), (0x1, 4).
REQ-037 s_nbits edge cases: s_nbits=0 with s_last=1 -> treated as 8 bits; s_nbits=1, s_data=0x01 -> single chunk (0x1, 1), then stream_done.
